demodulator_arbiter: RTL and testbench

Round-robin arbiter that shares one demodulator datapath among `NReq` independent requesters using val/rdy streams. It accepts one sample from a selected requester and forwards it to the demodulator. It then waits for the demodulator's result and returns that result to the same requester before granting again. The block sits between the per-channel front ends and a single `demodulator_Demodulator` instance, so the demodulator needs no channel awareness.

---
 rtl/demodulator_arbiter.sv | 110 +++++++++++
 tb/tb_demodulator_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demodulator_arbiter.sv
// Round-robin arbiter sharing one demodulator among NReq val/rdy requesters.
// One transaction is in flight at a time: accept, issue, wait for result, return.
module demodulator_arbiter #(
    parameter int Width = 32,
    parameter int NReq  = 4,
    localparam int GW   = $clog2(NReq)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NReq-1:0]       recv_val,
    output logic [NReq-1:0]       recv_rdy,
    input  logic [NReq*Width-1:0] recv_msg,
    output logic [NReq-1:0]       send_val,
    input  logic [NReq-1:0]       send_rdy,
    output logic [Width-1:0]      send_msg,
    output logic                  dm_req_val,
    input  logic                  dm_req_rdy,
    output logic [Width-1:0]      dm_req_msg,
    input  logic                  dm_resp_val,
    output logic                  dm_resp_rdy,
    input  logic [Width-1:0]      dm_resp_msg,
    output logic [GW-1:0]         grant,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_RETURN = 2'd3
    } state_t;

    state_t            state;
    logic [GW-1:0]     ptr;
    logic [Width-1:0]  req_q;
    logic [Width-1:0]  resp_q;

    logic              found;
    logic [GW-1:0]     sel;
    logic [GW:0]       idx;

    // Scan downward so the candidate closest to ptr (smallest offset) wins last.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = NReq - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (GW+1)'(k);
            if (idx >= (GW+1)'(NReq)) idx = idx - (GW+1)'(NReq);
            if (recv_val[idx[GW-1:0]]) begin
                found = 1'b1;
                sel   = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        recv_rdy = '0;
        if (state == S_IDLE && found) recv_rdy[sel] = 1'b1;
    end

    always_comb begin
        send_val = '0;
        if (state == S_RETURN) send_val[grant] = 1'b1;
    end

    assign dm_req_val  = (state == S_ISSUE);
    assign dm_resp_rdy = (state == S_WAIT);
    assign dm_req_msg  = req_q;
    assign send_msg    = resp_q;
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            ptr    <= '0;
            grant  <= '0;
            req_q  <= '0;
            resp_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        req_q <= recv_msg[int'(sel)*Width +: Width];
                        grant <= sel;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (dm_req_rdy) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (dm_resp_val) begin
                        resp_q <= dm_resp_msg;
                        state  <= S_RETURN;
                    end
                end
                S_RETURN: begin
                    // The pointer only moves once the result has been handed back.
                    if (send_rdy[grant]) begin
                        ptr   <= (grant == GW'(NReq - 1)) ? '0 : grant + 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demodulator_arbiter.sv
// Bench for demodulator_arbiter: transaction-level reference model checked every cycle.
module tb_demodulator_arbiter;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int GW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [N-1:0]   recv_val, recv_rdy, send_val, send_rdy;
    logic [N*W-1:0] recv_msg;
    logic [W-1:0]   send_msg, dm_req_msg, dm_resp_msg;
    logic           dm_req_val, dm_req_rdy, dm_resp_val, dm_resp_rdy;
    logic [GW-1:0]  grant;
    logic           busy;

    demodulator_arbiter #(.Width(W), .NReq(N)) dut (
        .clk(clk), .reset(reset),
        .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
        .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
        .dm_req_val(dm_req_val), .dm_req_rdy(dm_req_rdy), .dm_req_msg(dm_req_msg),
        .dm_resp_val(dm_resp_val), .dm_resp_rdy(dm_resp_rdy), .dm_resp_msg(dm_resp_msg),
        .grant(grant), .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: one open transaction with progress flags.
    bit           m_open, m_issued, m_got;
    int           m_who, m_ptr, m_grant;
    logic [W-1:0] m_sample, m_result;

    logic [GW-1:0] order[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (recv_val[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_open = 0; m_issued = 0; m_got = 0;
        m_who = 0; m_ptr = 0; m_grant = 0;
        m_sample = '0; m_result = '0;
    endtask

    // Called at a falling edge with inputs applied; compares, then advances one clock.
    task automatic step();
        int p;
        if (reset) model_reset();
        #2;
        p = m_open ? -1 : pick();
        check("recv_rdy",    recv_rdy,    onehot(p));
        check("dm_req_val",  dm_req_val,  m_open && !m_issued);
        check("dm_resp_rdy", dm_resp_rdy, m_open && m_issued && !m_got);
        check("send_val",    send_val,    (m_open && m_got) ? onehot(m_who) : '0);
        check("send_msg",    send_msg,    m_result);
        check("dm_req_msg",  dm_req_msg,  m_sample);
        check("grant",       grant,       m_grant);
        check("busy",        busy,        m_open);
        @(posedge clk);
        if (reset) model_reset();
        else if (!m_open) begin
            if (p >= 0) begin
                m_open = 1; m_issued = 0; m_got = 0;
                m_who = p; m_grant = p;
                m_sample = recv_msg[p*W +: W];
            end
        end else if (!m_issued) begin
            if (dm_req_rdy) m_issued = 1;
        end else if (!m_got) begin
            if (dm_resp_val) begin
                m_got = 1;
                m_result = dm_resp_msg;
            end
        end else if (send_rdy[m_who]) begin
            m_open = 0;
            m_ptr = (m_who + 1) % N;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        recv_val = '0; dm_req_rdy = 1; dm_resp_val = 1; send_rdy = '1;
        for (int c = 0; c < 12 && m_open; c++) begin
            dm_resp_msg = $urandom;
            step();
        end
        dm_resp_val = 0;
        #1 check("drain_busy", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        model_reset();
        reset = 1; recv_val = '0; recv_msg = '0; send_rdy = '1;
        dm_req_rdy = 1; dm_resp_val = 0; dm_resp_msg = '0;

        // Reset, no traffic
        @(negedge clk);
        step();
        reset = 0;
        step();
        step();
        #1;
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_send_val", send_val, 0);
        check("rst_dm_req_val", dm_req_val, 0);
        check("rst_recv_rdy", recv_rdy, 0);

        // Single requester, loopback D=1
        recv_val = 4'b0100;
        recv_msg[2*W +: W] = 32'h0000_00A5;
        step();
        recv_val = '0;
        #1;
        check("lb_dm_req_val", dm_req_val, 1);
        check("lb_dm_req_msg", dm_req_msg, 32'hA5);
        step();
        dm_resp_val = 1; dm_resp_msg = 32'hA5;
        step();
        dm_resp_val = 0;
        #1;
        check("lb_send_val", send_val, 4'b0100);
        check("lb_send_msg", send_msg, 32'hA5);
        check("lb_grant", grant, 2);
        step();
        recv_val = 4'b1001;
        #1 check("lb_next_ptr", recv_rdy, 4'b1000);
        recv_val = '0;

        // Round-robin fairness from reset
        reset = 1;
        step();
        reset = 0;
        recv_val = 4'hF;
        for (int i = 0; i < N; i++) recv_msg[i*W +: W] = W'(i);
        dm_req_rdy = 1; send_rdy = '1; dm_resp_val = 1;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            dm_resp_msg = m_sample;
            if (m_open && !m_issued) order.push_back(grant);
            step();
        end
        check("fair_count", order.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < order.size()) check("fair_order", order[i], exp_order[i]);
        drain();

        // Back-pressure on the demodulator request and on the result
        recv_val = 4'b0010;
        recv_msg[1*W +: W] = 32'h77;
        dm_req_rdy = 0; dm_resp_val = 0; send_rdy = '1;
        step();
        recv_val = 4'hF;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_issue_msg", dm_req_msg, 32'h77);
            check("bp_issue_rdy", recv_rdy, 0);
            step();
        end
        dm_req_rdy = 1;
        step();
        dm_resp_val = 1; dm_resp_msg = 32'h99;
        step();
        dm_resp_val = 0; send_rdy = 4'b1101;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("bp_ret_msg", send_msg, 32'h99);
            check("bp_ret_val", send_val, 4'b0010);
            check("bp_ret_rdy", recv_rdy, 0);
            step();
        end
        send_rdy = '1;
        step();
        drain();

        // Spurious result while issuing
        recv_val = 4'b0001;
        recv_msg[0 +: W] = 32'h55;
        dm_req_rdy = 0;
        step();
        recv_val = '0;
        dm_resp_val = 1; dm_resp_msg = 32'hDEAD;
        step();
        dm_req_rdy = 1;
        step();
        dm_resp_msg = 32'h1234;
        step();
        dm_resp_val = 0;
        #1 check("spur_send_msg", send_msg, 32'h1234);
        step();

        // Reset in the middle of a transaction
        recv_val = 4'b0100;
        step();
        recv_val = '0;
        step();
        #1 check("mid_in_wait", dm_resp_rdy, 1);
        reset = 1;
        #1 check("mid_busy", busy, 0);
        step();
        reset = 0;
        dm_resp_val = 1; dm_resp_msg = 32'hBEEF;
        for (int c = 0; c < 4; c++) begin
            #1 check("mid_no_send", send_val, 0);
            step();
        end
        dm_resp_val = 0;
        recv_val = 4'b1001;
        #1 check("mid_ptr_zero", recv_rdy, 4'b0001);
        recv_val = '0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 199) == 0);
            recv_val    = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            recv_msg    = {$urandom, $urandom, $urandom, $urandom};
            dm_req_rdy  = ($urandom_range(0, 3) != 0);
            dm_resp_val = $urandom_range(0, 1);
            dm_resp_msg = $urandom;
            send_rdy    = N'($urandom) | N'($urandom);
            step();
        end
        reset = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
